muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. Sits in the execute stage beside `alu`, takes the forwarded source operands, and runs MULT/MULTU/DIV/DIVU over 33 cycles. It also services MTHI/MTLO writes and MFHI/MFLO reads. While it is busy, `busy` drives the hazard unit, which stalls F/D and bubbles E.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state enum and iteration count.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int unsigned ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles (32 RUN + 1 FIX); MTHI/MTLO write
// immediately.
// Ports:
//   clk, reset (async, active-low)
//   start, op[2:0], a, b : operation issue from E stage
//   rd_sel               : 0 = LO, 1 = HI
//   rd_data              : combinational read of selected register
//   busy                 : multicycle operation in flight
//   done                 : one-cycle pulse after HI/LO writeback
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(ITERS);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;       // {P_hi, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0] opnd;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] hi, lo;
  logic             is_div, neg_res, neg_rem, div_zero;

  logic             legal, accept, signed_op, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_x, add_y, add_r;
  logic [W2-1:0]    acc_step, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Issue decode and operand magnitudes
  always_comb begin
    legal     = (op <= OP_MTLO);
    accept    = start && (state_q == IDLE) && legal;
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    neg_a     = signed_op && a[WIDTH-1];
    neg_b     = signed_op && b[WIDTH-1];
    mag_a     = neg_a ? -a : a;
    mag_b     = neg_b ? -b : b;
  end

  // Shared (WIDTH+1)-bit adder: add for multiply, trial-subtract for divide
  always_comb begin
    add_x = is_div ? acc[W2-1:WIDTH-1] : {1'b0, acc[W2-1:WIDTH]};
    add_y = {1'b0, opnd};
    add_r = is_div ? (add_x - add_y) : (add_x + add_y);
    if (is_div) begin
      if (!add_r[WIDTH]) acc_step = {add_r[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_step = {acc[W2-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {add_r, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[W2-1:1]};
    end
  end

  // Signed fix-up; divide-by-zero forces all-ones quotient (remainder is a)
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = neg_rem ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !op[2]) state_d = RUN;
      RUN:     if (cnt == CW'(ITERS - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath, HI/LO and status flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: begin
                cnt      <= '0;
                is_div   <= op[1];
                neg_res  <= neg_a ^ neg_b;
                neg_rem  <= neg_a;
                div_zero <= (b == '0);
                acc      <= op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                opnd     <= op[1] ? mag_b : mag_a;
              end
            endcase
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[W2-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus a
// randomized back-to-back stream compared against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;

  int tests;
  int fails;
  logic [31:0] mhi, mlo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one operation, computed with plain arithmetic
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          p;
    longint unsigned pu;
    int              q, r;
    case (o)
      OP_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        mhi = p[63:32];
        mlo = p[31:0];
      end
      OP_MULTU: begin
        pu = {32'd0, x} * {32'd0, y};
        mhi = pu[63:32];
        mlo = pu[31:0];
      end
      OP_DIV: begin
        if (y == 32'd0) begin
          mlo = 32'hFFFF_FFFF; mhi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          mlo = 32'h8000_0000; mhi = 32'd0;
        end else begin
          q = int'(x) / int'(y);
          r = int'(x) % int'(y);
          mlo = q; mhi = r;
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) begin
          mlo = 32'hFFFF_FFFF; mhi = x;
        end else begin
          mlo = x / y; mhi = x % y;
        end
      end
      OP_MTHI: mhi = x;
      OP_MTLO: mlo = x;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the first negedge after the accept edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    model(o, x, y);
  endtask

  task automatic read_regs(input string tag);
    rd_sel = 1'b1; #1;
    check({tag, "_hi"}, rd_data, mhi);
    rd_sel = 1'b0; #1;
    check({tag, "_lo"}, rd_data, mlo);
  endtask

  task automatic wait_done(input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 0) check({tag, "_done_low"}, 32'(done), 32'd0);
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    read_regs(tag);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    tests = 0; fails = 0;
    mhi = '0; mlo = '0;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd_sel = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    read_regs("rst");
    reset = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(33, "multu_max");
    @(negedge clk);
    check("multu_max_done_single", 32'(done), 32'd0);
    check("multu_max_exp_hi", mhi, 32'hFFFF_FFFE);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(33, "mult_neg");
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(33, "div_neg");
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_done(33, "divu");
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(33, "divu_zero");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(33, "div_ovf");
    issue(OP_DIV, 32'hFFFF_FFF3, 32'd0);
    wait_done(33, "div_zero_neg");
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(33, "mult_min");
    @(negedge clk);

    // Idle register writes and an illegal op
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_busy", 32'(busy), 32'd0);
    read_regs("mthi");
    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    check("mtlo_busy", 32'(busy), 32'd0);
    read_regs("mtlo");
    issue(3'b110, 32'hDEAD_BEEF, 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    read_regs("illegal");
    @(negedge clk);

    // Start while busy is ignored
    issue(OP_MULTU, 32'd3, 32'd4);
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(32, "busy_reject");
    @(negedge clk);

    // Asynchronous reset mid-operation
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (10) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    mhi = '0; mlo = '0;
    check("midrst_busy", 32'(busy), 32'd0);
    read_regs("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(33, "post_rst_divu");

    // Randomized back-to-back stream, issued in each done cycle
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      issue(ro, ra, rb);
      wait_done(33, "rand");
    end
    @(negedge clk);
    check("final_done_low", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
